// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: state encoding, widths and
// the byte-enable merge helper (also used by the instruction ROM loader).
package mem_pkg;

  localparam int unsigned CNT_W     = 4;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned NUM_BYTES = WORD_W / BYTE_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  typedef enum logic [1:0] {
    StIdle = S_IDLE,
    StBusy = S_BUSY,
    StResp = S_RESP
  } state_e;

  // Replace only the bytes whose enable is set; the rest come from old_word.
  function automatic logic [WORD_W-1:0] be_merge(input logic [WORD_W-1:0]    old_word,
                                                 input logic [WORD_W-1:0]    new_word,
                                                 input logic [NUM_BYTES-1:0] be);
    logic [WORD_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < int'(NUM_BYTES); i++) begin
      if (be[i]) begin
        merged[i*BYTE_W +: BYTE_W] = new_word[i*BYTE_W +: BYTE_W];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/data_mem_responder.sv
// Fixed-latency data-memory responder: one load/store at a time over valid/ready,
// single-cycle response pulse, plus a combinational debug read port.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned AW      = $clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [31:0]          req_addr_i,
  input  logic [WORD_W-1:0]    req_wdata_i,
  input  logic [NUM_BYTES-1:0] req_be_i,
  output logic                 resp_valid_o,
  output logic [WORD_W-1:0]    resp_rdata_o,
  output logic                 resp_err_o,
  input  logic [AW-1:0]        dbg_addr_i,
  output logic [WORD_W-1:0]    dbg_rdata_o
);

  logic [WORD_W-1:0]    mem_q [DEPTH];
  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 we_q;
  logic [31:0]          addr_q;
  logic [WORD_W-1:0]    wdata_q;
  logic [NUM_BYTES-1:0] be_q;
  logic                 req_ready_q;
  logic                 resp_valid_q;
  logic [WORD_W-1:0]    resp_rdata_q;
  logic                 resp_err_q;

  logic                 in_idle;
  logic                 accept;
  logic                 enter_resp;
  logic                 src_we;
  logic [31:0]          src_addr;
  logic [WORD_W-1:0]    src_wdata;
  logic [NUM_BYTES-1:0] src_be;
  logic [AW-1:0]        src_idx;
  logic                 src_err;
  logic [WORD_W-1:0]    rd_word;

  // With LATENCY==1 the accept edge is also the commit edge, so the request is
  // taken straight from the ports; otherwise the latched copy is used.
  always_comb begin
    in_idle    = (state_q == StIdle);
    accept     = req_valid_i && req_ready_q;
    enter_resp = (accept && (LATENCY == 1)) || ((state_q == StBusy) && (cnt_q == '0));
    src_we     = in_idle ? req_we_i    : we_q;
    src_addr   = in_idle ? req_addr_i  : addr_q;
    src_wdata  = in_idle ? req_wdata_i : wdata_q;
    src_be     = in_idle ? req_be_i    : be_q;
    src_idx    = src_addr[AW+1:2];
    src_err    = (src_addr[1:0] != 2'b00) || (src_addr[31:2] >= 30'(DEPTH));
    rd_word    = mem_q[src_idx];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (enter_resp) begin
        resp_valid_q <= 1'b1;
        resp_err_q   <= src_err;
        resp_rdata_q <= (src_err || src_we) ? '0 : rd_word;
        if (!src_err && src_we) begin
          mem_q[src_idx] <= be_merge(rd_word, src_wdata, src_be);
        end
      end

      unique case (state_q)
        StIdle: begin
          if (accept) begin
            we_q        <= req_we_i;
            addr_q      <= req_addr_i;
            wdata_q     <= req_wdata_i;
            be_q        <= req_be_i;
            req_ready_q <= 1'b0;
            if (LATENCY == 1) begin
              state_q <= StResp;
            end else begin
              state_q <= StBusy;
              cnt_q   <= CNT_W'(LATENCY - 2);
            end
          end
        end
        StBusy: begin
          if (cnt_q == '0) begin
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        StResp: begin
          state_q      <= StIdle;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
          resp_rdata_q <= '0;
          resp_err_q   <= 1'b0;
        end
        default: begin
          state_q     <= StIdle;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;
  assign dbg_rdata_o  = mem_q[dbg_addr_i];

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (LATENCY 2, 1, 5) driven by directed
// and random requests, checked against a word-array reference model.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_we    [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic [3:0]  req_be    [3];
  logic        resp_valid[3];
  logic [31:0] resp_rdata[3];
  logic        resp_err  [3];
  logic [2:0]  dbg_addr  [3];
  logic [31:0] dbg_rdata [3];

  logic [31:0] mdl [3][8];
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned Lat = (g == 0) ? 2 : (g == 1) ? 1 : 5;
    data_mem_responder #(
      .DEPTH  (8),
      .LATENCY(Lat),
      .AW     (3)
    ) u_dut (
      .clk_i       (clk),
      .reset_i     (reset),
      .req_valid_i (req_valid[g]),
      .req_ready_o (req_ready[g]),
      .req_we_i    (req_we[g]),
      .req_addr_i  (req_addr[g]),
      .req_wdata_i (req_wdata[g]),
      .req_be_i    (req_be[g]),
      .resp_valid_o(resp_valid[g]),
      .resp_rdata_o(resp_rdata[g]),
      .resp_err_o  (resp_err[g]),
      .dbg_addr_i  (dbg_addr[g]),
      .dbg_rdata_o (dbg_rdata[g])
    );
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : 5;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_mem(input int k, input string tag);
    for (int w = 0; w < 8; w++) begin
      dbg_addr[k] = 3'(w);
      #1;
      check($sformatf("%s dbg[%0d] inst%0d", tag, w, k), dbg_rdata[k], mdl[k][w]);
    end
  endtask

  // Issue one request and check latency, handshake and response against the model.
  task automatic do_req(input int k, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input bit junk,
                        input string tag);
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [31:0] mask;
    int          lat;
    bit          seen;
    exp_err   = (addr % 4 != 0) || (addr / 4 >= 8);
    exp_rdata = (exp_err || we) ? 32'h0 : mdl[k][addr / 4];

    @(negedge clk);
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    req_be[k]    = be;
    check({tag, " ready before accept"}, 32'(req_ready[k]), 32'd1);

    lat  = 0;
    seen = 1'b0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(negedge clk);
      if (resp_valid[k]) begin
        seen = 1'b1;
        lat  = c;
        req_valid[k] = 1'b0;
        check({tag, " err"}, 32'(resp_err[k]), 32'(exp_err));
        check({tag, " rdata"}, resp_rdata[k], exp_rdata);
      end else if (junk) begin
        req_valid[k] = 1'b1;
        req_we[k]    = 1'b1;
        req_addr[k]  = 32'h0;
        req_wdata[k] = 32'hFFFF_FFFF;
        req_be[k]    = 4'hF;
      end else begin
        req_valid[k] = 1'b0;
      end
      check({tag, " ready low while busy"}, 32'(req_ready[k]), 32'd0);
    end
    req_valid[k] = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'(lat_of(k)));

    if (!exp_err && we) begin
      mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      mdl[k][addr / 4] = (mdl[k][addr / 4] & ~mask) | (wdata & mask);
    end

    @(negedge clk);
    check({tag, " ready after pulse"}, 32'(req_ready[k]), 32'd1);
    check({tag, " single pulse"}, 32'(resp_valid[k]), 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    int          k;
    int          sel;

    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_valid[i] = 1'b0;
      req_we[i]    = 1'b0;
      req_addr[i]  = '0;
      req_wdata[i] = '0;
      req_be[i]    = '0;
      dbg_addr[i]  = '0;
      for (int w = 0; w < 8; w++) mdl[i][w] = '0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset ready inst%0d", i), 32'(req_ready[i]), 32'd1);
      check($sformatf("reset valid inst%0d", i), 32'(resp_valid[i]), 32'd0);
      check($sformatf("reset rdata inst%0d", i), resp_rdata[i], 32'd0);
      check($sformatf("reset err inst%0d", i), 32'(resp_err[i]), 32'd0);
      check_mem(i, "reset");
    end

    // Store then load
    do_req(0, 1'b1, 32'h8, 32'hDEAD_BEEF, 4'hF, 1'b0, "st8");
    do_req(0, 1'b0, 32'h8, 32'h0, 4'h0, 1'b0, "ld8");
    check("ld8 literal", mdl[0][2], 32'hDEAD_BEEF);

    // Partial byte-enable merge
    do_req(0, 1'b1, 32'h4, 32'hAABB_CCDD, 4'hF, 1'b0, "st4 full");
    do_req(0, 1'b1, 32'h4, 32'h1122_3344, 4'b0101, 1'b0, "st4 be5");
    dbg_addr[0] = 3'd1;
    #1;
    check("merge dbg1", dbg_rdata[0], 32'hAA22_CC44);
    do_req(0, 1'b1, 32'h4, 32'h5555_5555, 4'h0, 1'b0, "st4 be0");
    check_mem(0, "after merges");

    // Errors
    do_req(0, 1'b0, 32'h6, 32'h0, 4'hF, 1'b0, "ld misaligned");
    do_req(0, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0, "ld out of range");
    do_req(0, 1'b1, 32'h22, 32'h1234_5678, 4'hF, 1'b0, "st 0x22");
    do_req(0, 1'b1, 32'h8000_0004, 32'h1234_5678, 4'hF, 1'b0, "st high bits");
    check_mem(0, "after errors");

    // Latency 1 and 5 with a request presented while busy
    do_req(1, 1'b1, 32'h1C, 32'hCAFE_F00D, 4'hF, 1'b1, "lat1 st");
    do_req(2, 1'b1, 32'h10, 32'h0BAD_CAFE, 4'hF, 1'b1, "lat5 st");
    do_req(2, 1'b0, 32'h10, 32'h0, 4'hF, 1'b1, "lat5 ld");
    check_mem(1, "lat1 mem");
    check_mem(2, "lat5 mem");

    // Random traffic
    for (int n = 0; n < 60; n++) begin
      k   = $urandom_range(0, 2);
      sel = $urandom_range(0, 9);
      if (sel == 0) a = (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(1, 3));
      else if (sel == 1) a = 32'($urandom_range(8, 1000)) << 2;
      else a = 32'($urandom_range(0, 7)) << 2;
      do_req(k, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
    end
    for (int i = 0; i < 3; i++) check_mem(i, "random");

    // Reset during BUSY, coinciding with the commit edge
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_addr[0]  = 32'hC;
    req_wdata[0] = 32'h7777_7777;
    req_be[0]    = 4'hF;
    @(negedge clk);
    req_valid[0] = 1'b0;
    reset        = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) for (int w = 0; w < 8; w++) mdl[i][w] = '0;
    check("abort ready", 32'(req_ready[0]), 32'd1);
    for (int c = 0; c < 4; c++) begin
      check($sformatf("abort no pulse c%0d", c), 32'(resp_valid[0]), 32'd0);
      @(negedge clk);
    end
    check_mem(0, "abort");
    do_req(0, 1'b0, 32'hC, 32'h0, 4'hF, 1'b0, "ld after abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
